// File: rtl/rv_opcodes_pkg.sv
// Shared RV64 opcode table and register-use decode.
// The decoder and the hazard logic both take their view of an instruction from here.
package rv_opcodes_pkg;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;

  // Which register fields an instruction actually uses.
  typedef struct packed {
    logic use1;  // reads rs1
    logic use2;  // reads rs2
    logic wr;    // writes rd
  } reg_use_t;

  // Unknown opcodes read nothing and write nothing, so they never stall.
  function automatic reg_use_t decode_use(input logic [6:0] op);
    reg_use_t u;
    u = '0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL:   u = '{use1: 1'b0, use2: 1'b0, wr: 1'b1};
      OP_JALR, OP_LOAD,
      OP_OP_IMM, OP_OP_IMM_32:    u = '{use1: 1'b1, use2: 1'b0, wr: 1'b1};
      OP_BRANCH, OP_STORE:        u = '{use1: 1'b1, use2: 1'b1, wr: 1'b0};
      OP_OP, OP_OP_32:            u = '{use1: 1'b1, use2: 1'b1, wr: 1'b1};
      default:                    u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count.
// Read data is the head entry, available combinationally.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;

  assign do_push = push && !flush;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write; an entry only becomes visible through the pointers/count.
  // NOTE: the array is deliberately not reset -- validity comes from count, and a reset
  // on storage would cost a flop reset per bit for no functional gain.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue buffer between fetch and decode. Holds the head instruction
// while any register it reads or writes has a write-back still outstanding.
module issue_scoreboard
  import rv_opcodes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [PC_W-1:0]              out_pc,
  input  logic                         wb_valid,
  input  logic [4:0]                   wb_rd,
  output logic                         stall_raw,
  output logic [31:0]                  busy_mask,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int ENT_W = PC_W + 32;

  logic [ENT_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             issue;
  logic [31:0]      busy_q;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  reg_use_t         head_use;
  logic             hazard;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (issue),
    .wdata ({in_pc, in_instr}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_pc    = head[ENT_W-1:32];
  assign out_instr = head[31:0];
  assign busy_mask = busy_q;

  assign rd       = out_instr[11:7];
  assign rs1      = out_instr[19:15];
  assign rs2      = out_instr[24:20];
  assign head_use = decode_use(out_instr[6:0]);

  // Hazard check against the registered scoreboard only: a write-back this cycle
  // does not release a dependent until the following cycle.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    hazard = 1'b0;
    if (head_use.use1 && busy_q[rs1]) hazard = 1'b1;
    if (head_use.use2 && busy_q[rs2]) hazard = 1'b1;
    if (head_use.wr   && busy_q[rd])  hazard = 1'b1;
  end

  assign out_valid = !fifo_empty && !hazard;
  assign stall_raw = !fifo_empty &&  hazard;
  assign issue     = out_valid && out_ready;

  // Set/clear requests for this edge; x0 is never tracked.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && head_use.wr && (rd != 5'd0)) set_mask[rd]    = 1'b1;
    if (wb_valid && (wb_rd != 5'd0))         clr_mask[wb_rd] = 1'b1;
  end

  // Scoreboard update; flush leaves it alone because issued ops still write back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end
  end

  // A set and clear of the same register would mean a WAW slipped through.
  a_no_set_clr_overlap: assert property (@(posedge clk) disable iff (!reset)
    ((set_mask & clr_mask) == 32'd0))
    else $error("scoreboard set and clear collide on the same register");

  // Write-back for a register nobody is waiting on points at an upstream bug.
  a_wb_targets_busy: assert property (@(posedge clk) disable iff (!reset)
    (wb_valid && (wb_rd != 5'd0)) |-> busy_q[wb_rd])
    else $error("write-back to a register that is not busy");

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios followed by random
// traffic, all compared against a queue-and-bitmap reference model.
module tb_issue_scoreboard;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic              stall_raw;
  logic [31:0]       busy_mask;
  logic [2:0]        count;

  issue_scoreboard #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .stall_raw (stall_raw),
    .busy_mask (busy_mask),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of buffered instructions and a per-register busy flag.
  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  ent_t        mq[$];
  bit   [31:0] mbusy;
  int          n_vec;
  int          n_err;
  logic [63:0] pc_ctr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register usage straight from the ISA table.
  function automatic void ref_use(input logic [6:0] op, output bit r1, output bit r2, output bit w);
    r1 = (op == 7'b1100111) || (op == 7'b1100011) || (op == 7'b0000011) || (op == 7'b0100011) ||
         (op == 7'b0010011) || (op == 7'b0011011) || (op == 7'b0110011) || (op == 7'b0111011);
    r2 = (op == 7'b1100011) || (op == 7'b0100011) || (op == 7'b0110011) || (op == 7'b0111011);
    w  = (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111) || (op == 7'b1100111) ||
         (op == 7'b0000011) || (op == 7'b0010011) || (op == 7'b0011011) || (op == 7'b0110011) ||
         (op == 7'b0111011);
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    flush     = 1'b0;
  endtask

  task automatic offer(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 64'd4;
  endtask

  // One clock: compare outputs against the model, take the edge, advance the model.
  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit          emp, haz, u1, u2, w, iss, enq;
    logic [31:0] hi;
    #1;
    emp = (mq.size() == 0);
    haz = 1'b0;
    u1 = 0; u2 = 0; w = 0;
    hi = '0;
    if (!emp) begin
      hi = mq[0].instr;
      ref_use(hi[6:0], u1, u2, w);
      haz = (u1 && mbusy[hi[19:15]]) || (u2 && mbusy[hi[24:20]]) || (w && mbusy[hi[11:7]]);
    end
    check("out_valid", {63'd0, out_valid}, {63'd0, !emp && !haz});
    check("stall_raw", {63'd0, stall_raw}, {63'd0, !emp && haz});
    check("in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < DEPTH});
    check("count",     {61'd0, count},     64'(mq.size()));
    check("busy_mask", {32'd0, busy_mask}, {32'd0, mbusy});
    if (!emp) begin
      check("out_instr", {32'd0, out_instr}, {32'd0, hi});
      check("out_pc",    out_pc,             mq[0].pc);
    end
    iss = !emp && !haz && out_ready;
    enq = in_valid && (mq.size() < DEPTH) && !flush;
    @(posedge clk);
    if (wb_valid && wb_rd != 5'd0) mbusy[wb_rd] = 1'b0;
    if (iss) begin
      if (w && hi[11:7] != 5'd0) mbusy[hi[11:7]] = 1'b1;
      void'(mq.pop_front());
    end
    if (flush) mq.delete();
    else if (enq) mq.push_back('{pc: in_pc, instr: in_instr});
    @(negedge clk);
  endtask

  task automatic writeback(input logic [4:0] r);
    idle_inputs();
    wb_valid = 1'b1;
    wb_rd    = r;
    cycle();
    idle_inputs();
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy = '0;
  endtask

  // Random instruction with registers drawn from x0..x7 so hazards are frequent.
  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'b1110011};
    r        = $urandom;
    r[6:0]   = ops[$urandom_range(0, 11)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    n_vec  = 0;
    n_err  = 0;
    pc_ctr = 64'h8000_0000;
    mbusy  = '0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_stall_raw", {63'd0, stall_raw}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_count",     {61'd0, count},     64'd0);
    check("rst_busy",      {32'd0, busy_mask}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // 1: addi x5,x0,1 becomes visible the cycle after it is written, then sets x5.
    offer(32'h0010_0293);
    cycle();
    idle_inputs();
    check("t1_visible", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    cycle();
    idle_inputs();
    check("t1_busy", {32'd0, busy_mask}, 64'h20);

    // 2: add x6,x5,x5 waits for x5, issues the cycle after write-back, then sets x6.
    offer(32'h0052_8333);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t2_stall", {63'd0, stall_raw}, 64'd1);
    check("t2_hold",  {63'd0, out_valid}, 64'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    cycle();
    wb_valid = 1'b0;
    check("t2_release", {63'd0, out_valid}, 64'd1);
    cycle();
    check("t2_busy", {32'd0, busy_mask}, 64'h40);
    writeback(5'd6);

    // 3: fill with four lui (x8..x11), then drain one per cycle in order.
    for (int k = 0; k < 4; k++) begin
      offer({20'(k + 1), 5'(8 + k), 7'b0110111});
      cycle();
    end
    idle_inputs();
    check("t3_count", {61'd0, count}, 64'd4);
    check("t3_full",  {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_order", {32'd0, out_instr}, {32'd0, 20'(k + 1), 5'(8 + k), 7'b0110111});
      cycle();
      if (k == 0) check("t3_ready_after_first", {63'd0, in_ready}, 64'd1);
    end
    idle_inputs();
    for (int k = 8; k < 12; k++) writeback(5'(k));

    // 4: lui x0 and sw x1,0(x2) never set busy bits.
    offer(32'h1234_5037);
    cycle();
    offer(32'h0011_2023);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    idle_inputs();
    check("t4_busy", {32'd0, busy_mask}, 64'd0);

    // 5: x7 busy, three queued, flush with an offer pending -> empty, x7 still busy.
    offer(32'h0010_0393);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      offer(32'h0000_0013);
      cycle();
    end
    offer(32'h0000_0013);
    flush = 1'b1;
    cycle();
    idle_inputs();
    check("t5_count", {61'd0, count},     64'd0);
    check("t5_busy",  {32'd0, busy_mask}, 64'h80);
    cycle();
    check("t5_dropped", {61'd0, count}, 64'd0);

    // 6: async reset with two queued and x7 busy clears everything before the next edge.
    for (int k = 0; k < 2; k++) begin
      offer(32'h0000_0013);
      cycle();
    end
    idle_inputs();
    check("t6_pre_count", {61'd0, count}, 64'd2);
    #2 reset = 1'b0;
    #1;
    check("t6_count",     {61'd0, count},     64'd0);
    check("t6_busy",      {32'd0, busy_mask}, 64'd0);
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_stall",     {63'd0, stall_raw}, 64'd0);
    check("t6_in_ready",  {63'd0, in_ready},  64'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic; write-backs only target registers the model holds busy.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      if ($urandom_range(0, 3) != 0) offer(rand_instr());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      if (mbusy != 0 && $urandom_range(0, 1) == 1) begin
        int pick;
        pick = $urandom_range(1, 31);
        while (!mbusy[pick]) pick = (pick % 31) + 1;
        wb_valid = 1'b1;
        wb_rd    = 5'(pick);
      end
      cycle();
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
